game_countdown_timer: RTL

- Consumes the slow square wave from the board clock divider (about 100 Hz from the 50 MHz board clock).
- Produces the round countdown (seconds, 2-digit BCD) for the rhythm game.
- The slow wave is sampled as data in the single system clock domain; it is never used as a clock.
- Drives the score/timer display and signals end-of-round to the game controller.

---
 rtl/game_timer_pkg.sv | 22 ++
 rtl/tick_sync_edge.sv | 28 ++
 rtl/game_countdown_timer.sv | 110 +++++++++++
 3 files changed

// File: rtl/game_timer_pkg.sv
// Shared types and helpers for the round countdown timer.
package game_timer_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timer_state_t;

    // Packs a 0..99 value as {tens, ones} BCD digits.
    function automatic logic [2*BCD_W-1:0] bcd_of_int(input int unsigned value);
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
        tens = BCD_W'(value / 10);
        ones = BCD_W'(value % 10);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/tick_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// Usable for any slow asynchronous level such as a divider output or a button.
module tick_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_pulse
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            prev       <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            sync1      <= async_in;
            sync2      <= sync1;
            prev       <= sync2;
            rise_pulse <= sync2 & ~prev;
        end
    end

endmodule

// File: rtl/game_countdown_timer.sv
// Round countdown for the rhythm game: BCD seconds driven by the slow divider wave,
// with start/pause/clear control and an end-of-round pulse.
module game_countdown_timer
    import game_timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100,
    parameter int INIT_SEC      = 60
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_in,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             running,
    output logic             done,
    output logic             time_up
);

    localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);
    localparam logic [2*BCD_W-1:0] INIT_BCD = bcd_of_int(INIT_SEC);
    localparam logic [BCD_W-1:0]   INIT_TENS = INIT_BCD[2*BCD_W-1:BCD_W];
    localparam logic [BCD_W-1:0]   INIT_ONES = INIT_BCD[BCD_W-1:0];

    timer_state_t     state, state_d;
    logic [PRE_W-1:0] prescaler, pre_d;
    logic [BCD_W-1:0] tens_d, ones_d;
    logic             time_up_d;
    logic             tick_evt;

    tick_sync_edge u_tick_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (tick_in),
        .rise_pulse (tick_evt)
    );

    always_comb begin
        state_d   = state;
        pre_d     = prescaler;
        tens_d    = sec_tens;
        ones_d    = sec_ones;
        time_up_d = 1'b0;
        if (clear) begin
            state_d = IDLE;
            pre_d   = '0;
            tens_d  = INIT_TENS;
            ones_d  = INIT_ONES;
        end else if (start && (state == IDLE || state == DONE)) begin
            pre_d  = '0;
            tens_d = INIT_TENS;
            ones_d = INIT_ONES;
            if (INIT_SEC == 0) begin
                state_d   = DONE;
                time_up_d = 1'b1;
            end else begin
                state_d = RUN;
            end
        end else if (state == RUN) begin
            if (tick_evt) begin
                if (prescaler == PRE_LAST) begin
                    pre_d = '0;
                    // Borrow from tens on ones underflow; 00 is a floor.
                    if (sec_ones != '0) begin
                        ones_d = sec_ones - 1'b1;
                    end else if (sec_tens != '0) begin
                        ones_d = BCD_W'(9);
                        tens_d = sec_tens - 1'b1;
                    end
                    if (sec_tens == '0 && sec_ones == BCD_W'(1)) begin
                        state_d   = DONE;
                        time_up_d = 1'b1;
                    end
                end else begin
                    pre_d = prescaler + 1'b1;
                end
            end
            // A pause arriving with the final tick is dropped in favour of DONE.
            if (pause && state_d != DONE) begin
                state_d = PAUSE;
            end
        end else if (state == PAUSE && pause) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            prescaler <= '0;
            sec_tens  <= INIT_TENS;
            sec_ones  <= INIT_ONES;
            running   <= 1'b0;
            done      <= 1'b0;
            time_up   <= 1'b0;
        end else begin
            state     <= state_d;
            prescaler <= pre_d;
            sec_tens  <= tens_d;
            sec_ones  <= ones_d;
            running   <= (state_d == RUN);
            done      <= (state_d == DONE);
            time_up   <= time_up_d;
        end
    end

endmodule
